// File: rtl/arb_data_memory_pkg.sv
// ============================================================================
// Package : mm_mem_pkg
// Purpose : Shared defaults and helpers for the arbitrated data memory.
//           DEF_* give the default data width, address width and core count.
//           MAX_CORES is the largest supported core count. wsrc_e names the
//           source of the single write committed in a cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mm_mem_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_N_CORES = 4;
  localparam int MAX_CORES   = 8;

  // Source of the write that commits in the current cycle
  typedef enum logic [1:0] {
    WSRC_NONE = 2'd0,
    WSRC_HOST = 2'd1,
    WSRC_CORE = 2'd2
  } wsrc_e;

  // Pointer width for a round-robin index over n requesters (at least 1 bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_data_memory_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Round-robin one-hot arbiter for core write requests.
//           The search starts at the internal pointer and ascends with
//           wrap-around. The pointer moves to (winner + 1) mod N only when a
//           grant is issued.
// Ports   : clk, rst  - clock, synchronous active-high reset (pointer -> 0)
//           i_req [N] - write request vector
//           i_en      - arbitration enable (low: no grant, pointer frozen)
//           o_gnt [N] - one-hot grant (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import mm_mem_pkg::*;
#(
  parameter int N = DEF_N_CORES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_gnt
);

  localparam int PTR_W = ptr_width(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;
  int               w_idx;

  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (i_en && i_req[w_idx] && !w_found) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_ptr_nxt    = PTR_W'((w_idx + 1) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_data_memory.sv
// ============================================================================
// Module  : arb_data_memory
// Purpose : Single-array data memory shared by one host port and N_CORES core
//           ports. Reads are granted combinationally without limit and answer
//           one cycle later. At most one write commits per cycle: the host
//           wins outright, and core writes are arbitrated round-robin.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           host_req/we/addr/wdata   - host request
//           host_gnt/rvalid/rdata    - host grant and read response
//           core_* (packed, core i at [i*W +: W]) - same signals per core
// Config  : WR_FWD_EN - when defined, a read that hits the address being
//           written in the same cycle returns the new data. When undefined,
//           it returns the old data (read-first).
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_data_memory
  import mm_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int N_CORES = DEF_N_CORES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_req,
  input  logic                      host_we,
  input  logic [ADDR_W-1:0]         host_addr,
  input  logic [DATA_W-1:0]         host_wdata,
  output logic                      host_gnt,
  output logic                      host_rvalid,
  output logic [DATA_W-1:0]         host_rdata,
  input  logic [N_CORES-1:0]        core_req,
  input  logic [N_CORES-1:0]        core_we,
  input  logic [N_CORES*ADDR_W-1:0] core_addr,
  input  logic [N_CORES*DATA_W-1:0] core_wdata,
  output logic [N_CORES-1:0]        core_gnt,
  output logic [N_CORES-1:0]        core_rvalid,
  output logic [N_CORES*DATA_W-1:0] core_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_host_wr;
  logic               w_host_rd_gnt;
  logic [N_CORES-1:0] w_core_wr_req;
  logic [N_CORES-1:0] w_core_wr_gnt;
  logic [N_CORES-1:0] w_core_rd_gnt;
  logic               w_arb_en;

  wsrc_e              w_wsrc;
  logic               w_wr_en;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;

  // ---------------------------------------------------------------------------
  // Grants. Reset suppresses every grant, so no write can commit while rst=1.
  // ---------------------------------------------------------------------------
  assign w_host_wr     = host_req & host_we & ~rst;
  assign w_host_rd_gnt = host_req & ~host_we & ~rst;
  assign w_core_wr_req = core_req & core_we;
  assign w_core_rd_gnt = core_req & ~core_we & {N_CORES{~rst}};

  // A host write blocks core arbitration entirely, which also freezes rr_ptr
  assign w_arb_en = ~rst & ~w_host_wr;

  rr_arbiter #(
    .N (N_CORES)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_core_wr_req),
    .i_en  (w_arb_en),
    .o_gnt (w_core_wr_gnt)
  );

  assign host_gnt = w_host_wr | w_host_rd_gnt;
  assign core_gnt = w_core_rd_gnt | w_core_wr_gnt;

  // ---------------------------------------------------------------------------
  // Write port mux (the core grant is one-hot)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wsrc    = WSRC_NONE;
    w_wr_addr = '0;
    w_wr_data = '0;
    if (w_host_wr) begin
      w_wsrc    = WSRC_HOST;
      w_wr_addr = host_addr;
      w_wr_data = host_wdata;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (w_core_wr_gnt[i]) begin
          w_wsrc    = WSRC_CORE;
          w_wr_addr = core_addr[i*ADDR_W +: ADDR_W];
          w_wr_data = core_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_wr_en = (w_wsrc != WSRC_NONE);

  // Storage is never initialised and is not touched by reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: index 0..N_CORES-1 are cores, index N_CORES is the host.
  // Outputs are masked during reset. This drops a response that was already
  // registered when reset arrived.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p <= N_CORES; p++) begin : g_rd
    logic              w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    if (p == N_CORES) begin : g_host
      assign w_gnt  = w_host_rd_gnt;
      assign w_addr = host_addr;
      assign host_rvalid = r_rvalid & ~rst;
      assign host_rdata  = rst ? '0 : r_rdata;
    end else begin : g_core
      assign w_gnt  = w_core_rd_gnt[p];
      assign w_addr = core_addr[p*ADDR_W +: ADDR_W];
      assign core_rvalid[p] = r_rvalid & ~rst;
      assign core_rdata[p*DATA_W +: DATA_W] = rst ? '0 : r_rdata;
    end

`ifdef WR_FWD_EN
    assign w_word = (w_wr_en && (w_wr_addr == w_addr)) ? w_wr_data : r_mem[w_addr];
`else
    // The array is sampled before the same-edge write lands, so reads see old data
    assign w_word = r_mem[w_addr];
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_rvalid <= w_gnt;
        if (w_gnt) begin
          r_rdata <= w_word;
        end
      end
    end
  end

endmodule

`default_nettype wire
